// File: rtl/cdc_in_arbiter.sv
// Round-robin burst arbiter that merges N_SRC byte streams onto the single usb_cdc IN port.
// Define ARB_TAG_EN to prefix every grant with a tag byte 8'hA0 | owner index.
module cdc_in_arbiter #(
  parameter int N_SRC     = 2,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [8*N_SRC-1:0] src_data_i,
  input  logic [N_SRC-1:0]   src_valid_i,
  output logic [N_SRC-1:0]   src_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [N_SRC-1:0]   grant_o,
  output logic               busy_o
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef ARB_TAG_EN
    S_TAG   = 2'd2,
`endif
    S_BURST = 2'd1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_g, w_g_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [N_SRC-1:0] r_grant, w_grant_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic [7:0]      w_src_byte [N_SRC];
  logic [IW-1:0]   w_idx, w_pick;
  logic            w_found;
  logic            w_sel_valid;
  logic            w_xfer;

  for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
    assign w_src_byte[k] = src_data_i[8*k +: 8];
  end

  // Rotating priority: the first requester after the previous owner wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = r_last;
    for (int i = 1; i <= N_SRC; i++) begin
      w_idx = IW'((int'(r_last) + i) % N_SRC);
      if (!w_found && src_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_sel_valid = src_valid_i[r_g];
  assign w_xfer      = (r_state == S_BURST) && w_sel_valid && in_ready_i;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != S_IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    in_data_o   = 8'h00;
    in_valid_o  = 1'b0;
    src_ready_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_g_nxt     = w_pick;
          w_grant_nxt = {{(N_SRC-1){1'b0}}, 1'b1} << w_pick;
          w_cnt_nxt   = '0;
`ifdef ARB_TAG_EN
          w_state_nxt = S_TAG;
`else
          w_state_nxt = S_BURST;
`endif
        end
      end
`ifdef ARB_TAG_EN
      S_TAG: begin
        in_data_o  = 8'hA0 | 8'(r_g);
        in_valid_o = 1'b1;
        if (in_ready_i) w_state_nxt = S_BURST;
      end
`endif
      S_BURST: begin
        in_data_o        = w_src_byte[r_g];
        in_valid_o       = w_sel_valid;
        src_ready_o[r_g] = in_ready_i;
        if (w_xfer) w_cnt_nxt = r_cnt + 1'b1;
        // Release only on a byte boundary: either the burst is full or the owner went idle.
        if (!w_sel_valid || (w_xfer && r_cnt == CW'(MAX_BURST - 1))) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_g;
          w_grant_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_last  <= IW'(N_SRC - 1);
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Directed bench for cdc_in_arbiter: reset, single-source burst, round robin, stall, re-grant, reset mid-burst.
// The ARB_TAG_EN scenario runs only when the macro is defined for the build.
module tb_cdc_in_arbiter;

  localparam int N_SRC     = 2;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] src_data_i;
  logic [1:0]  src_valid_i;
  logic [1:0]  src_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int ptr0, ptr1;
  int base;

  logic       s_xfer, s_valid;
  logic [7:0] s_data;
  logic [1:0] s_ready, s_grant;
  logic [10:0] exp_v;

  cdc_in_arbiter #(.N_SRC(N_SRC), .MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .src_data_i  (src_data_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Byte n of each source's stream: src0 = 11,22,33,..., src1 = 55,56,57,...
  function automatic logic [7:0] d0(int n);
    return 8'((n + 1) * 17);
  endfunction

  function automatic logic [7:0] d1(int n);
    return 8'(8'h55 + n);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: present source bytes, sample the outputs that the coming edge will act on,
  // then advance each source whose byte was accepted.
  task automatic step();
    logic [1:0] acc;
    src_data_i = {d1(ptr1), d0(ptr0)};
    #1;
    s_valid = in_valid_o;
    s_data  = in_data_o;
    s_ready = src_ready_o;
    s_grant = grant_o;
    s_xfer  = in_valid_o & in_ready_i;
    acc     = src_ready_o & src_valid_i;
    @(posedge clk);
    #1;
    if (acc[0]) ptr0++;
    if (acc[1]) ptr1++;
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    src_valid_i = 2'b00;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    ptr0 = 0;
    ptr1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn        = 1'b0;
    src_valid_i = 2'b00;
    in_ready_i  = 1'b0;
    src_data_i  = '0;
    ptr0        = 0;
    ptr1        = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {grant_o, in_valid_o, in_data_o, src_ready_o, busy_o}, 0);
    rstn = 1'b1;

    // src0 sends three bytes, then drops valid.
    src_valid_i = 2'b01;
    in_ready_i  = 1'b1;
    step();
    check("t1_grant_latency", s_grant, 2'b00);
    check("t1_grant", grant_o, 2'b01);
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("t1_byte%0d", n), {s_valid, s_ready, s_data}, {1'b1, 2'b01, d0(n)});
    end
    src_valid_i = 2'b00;
    step();
    check("t1_drop_valid", s_valid, 1'b0);
    check("t1_release", {grant_o, busy_o}, 3'b000);

    // Both sources valid: 8 src0, idle, 8 src1, idle, 8 src0.
    do_reset();
    src_valid_i = 2'b11;
    for (int c = 0; c < 27; c++) begin
      step();
      if (c == 0 || c == 9 || c == 18) exp_v = '0;
      else if (c < 9)                  exp_v = {1'b1, 2'b01, d0(c - 1)};
      else if (c < 18)                 exp_v = {1'b1, 2'b10, d1(c - 10)};
      else                             exp_v = {1'b1, 2'b01, d0(c - 19 + 8)};
      check($sformatf("t2_cycle%0d", c), {s_xfer, s_grant, s_data}, exp_v);
    end
    src_valid_i = 2'b00;
    step();

    // Stall after byte 3: data and count hold, burst still ends after 8 bytes.
    src_valid_i = 2'b01;
    step();
    base = ptr0;
    for (int n = 0; n < 3; n++) step();
    in_ready_i = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      check($sformatf("t3_stall%0d", n), {s_valid, s_ready, s_data}, {1'b1, 2'b00, d0(base + 3)});
      check($sformatf("t3_cnt%0d", n), dut.r_cnt, 3);
    end
    in_ready_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check($sformatf("t3_resume%0d", n), {s_xfer, s_data}, {1'b1, d0(base + 3 + n)});
    end
    check("t3_burst_end", {grant_o, busy_o}, 3'b000);
    src_valid_i = 2'b00;
    step();

    // src1 alone: full burst, re-granted after one idle cycle; src0 then wins next.
    src_valid_i = 2'b10;
    step();
    check("t4_grant1", grant_o, 2'b10);
    for (int n = 0; n < 8; n++) step();
    check("t4_burst1_end", grant_o, 2'b00);
    step();
    check("t4_idle_gap", {s_valid, s_grant}, 3'b000);
    check("t4_regrant", grant_o, 2'b10);
    for (int n = 0; n < 8; n++) begin
      if (n == 3) src_valid_i = 2'b11;
      step();
      check($sformatf("t4_burst2_%0d", n), {s_xfer, s_grant}, 3'b110);
    end
    step();
    check("t4_src0_next", grant_o, 2'b01);
    src_valid_i = 2'b00;
    step();
    check("t4_src0_release", grant_o, 2'b00);

`ifdef ARB_TAG_EN
    // Tag byte precedes the payload and is never acknowledged to the source.
    ptr1 = 0;
    src_valid_i = 2'b10;
    step();
    step();
    check("t5_tag", {s_valid, s_ready, s_data}, {1'b1, 2'b00, 8'hA1});
    step();
    check("t5_payload", {s_xfer, s_ready, s_data}, {1'b1, 2'b10, 8'h55});
    src_valid_i = 2'b00;
    step();
`endif

    // Reset while src1 presents its fourth byte.
    src_valid_i = 2'b10;
    step();
`ifdef ARB_TAG_EN
    step();
`endif
    for (int n = 0; n < 3; n++) step();
    src_data_i = {d1(ptr1), d0(ptr0)};
    #1;
    check("t6_byte4_present", {in_valid_o, grant_o}, 3'b110);
    rstn = 1'b0;
    #1;
    check("t6_rst_async", {grant_o, in_valid_o, in_data_o, src_ready_o, busy_o}, 0);
    @(posedge clk);
    #1;
    check("t6_rst_held", {grant_o, in_valid_o, in_data_o, src_ready_o, busy_o}, 0);
    src_valid_i = 2'b11;
    rstn        = 1'b1;
    step();
    check("t6_first_grant", grant_o, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
